// File: rtl/shift_pkg.sv
// Shared definitions for the barrel-shifter datapath blocks (left and right shift).
// Holds the FSM state encoding, datapath widths and the carry-select encoding.
package shift_pkg;

    localparam int DATA_W  = 32;
    localparam int AMT_W   = 8;
    localparam int SAT_AMT = 33;
    // Remaining-count width: must hold 0..SAT_AMT.
    localparam int REM_W   = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Source of the next carry flag; same encoding as the right-shift block.
    typedef enum logic [1:0] {
        CSEL_HOLD  = 2'd0,
        CSEL_LOAD  = 2'd1,
        CSEL_SHIFT = 2'd2
    } csel_t;

    // Any amount above 32 behaves like 33: everything, including the carry, is shifted out.
    function automatic logic [REM_W-1:0] sat_amount(input logic [AMT_W-1:0] n);
        if (n > AMT_W'(SAT_AMT)) begin
            return REM_W'(SAT_AMT);
        end
        return n[REM_W-1:0];
    endfunction

endpackage

// File: rtl/lsl_step.sv
// Combinational single-step left shifter: shifts value by k (0..32) and
// reports the last bit shifted out. k=0 passes value and carry through.
module lsl_step
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    input  logic [REM_W-1:0]  k,
    input  logic              carry,
    output logic [DATA_W-1:0] value_out,
    output logic              carry_out
);

    logic [REM_W-1:0] idx;

    // Shift and pick the last bit to leave the word (bit DATA_W-k).
    always_comb begin
        value_out = value << k;
        idx       = REM_W'(DATA_W) - k;
        carry_out = carry;
        if ((k != '0) && (k <= REM_W'(DATA_W))) begin
            carry_out = value[idx[4:0]];
        end
    end

endmodule

// File: rtl/lsl_shift_seq.sv
// Multi-cycle ARM LSL unit: shifts a 32-bit operand left by up to 255 with
// ARMv7 carry-out, at most STEP bits per clock, using a Start/Busy/Done handshake.
// Optional Shift_Zero flag output is built when LSL_SHIFT_ZERO_FLAG_EN is defined.
//
// Handshake: Start is sampled only in IDLE or DONE (ignored while Busy);
// Done is a one-cycle pulse marking Shift_Out/Shift_Carry_Out valid, and the
// results hold until the next accepted Start. Start in DONE chains directly.
module lsl_shift_seq
    import shift_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        Start,
    input  logic [32:1] Shift_Data,
    input  logic [8:1]  Shift_Num,
    input  logic        Carry_In,
    output logic [32:1] Shift_Out,
    output logic        Shift_Carry_Out,
    output logic        Busy,
    output logic        Done,
`ifdef LSL_SHIFT_ZERO_FLAG_EN
    output logic        Shift_Zero,
`endif
    output state_t      dbg_state
);

    state_t            state, state_next;
    logic [REM_W-1:0]  rem, rem_next;
    logic [REM_W-1:0]  k;
    logic [32:1]       out_next;
    logic              carry_next;
    csel_t             csel;
    logic [DATA_W-1:0] step_value;
    logic              step_carry;

    // Bits to shift this cycle: the smaller of what remains and STEP.
    always_comb begin
        k = (rem < REM_W'(STEP)) ? rem : REM_W'(STEP);
    end

    lsl_step u_step (
        .value     (Shift_Out),
        .k         (k),
        .carry     (Shift_Carry_Out),
        .value_out (step_value),
        .carry_out (step_carry)
    );

    // Next-state and datapath-load decisions.
    always_comb begin
        state_next = state;
        rem_next   = rem;
        out_next   = Shift_Out;
        csel       = CSEL_HOLD;
        unique case (state)
            IDLE, DONE: begin
                if (Start) begin
                    out_next   = Shift_Data;
                    csel       = CSEL_LOAD;
                    rem_next   = sat_amount(Shift_Num);
                    state_next = (Shift_Num == '0) ? DONE : SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                out_next = step_value;
                csel     = CSEL_SHIFT;
                rem_next = rem - k;
                if (rem_next == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Carry source mux.
    always_comb begin
        carry_next = Shift_Carry_Out;
        unique case (csel)
            CSEL_LOAD:  carry_next = Carry_In;
            CSEL_SHIFT: carry_next = step_carry;
            default:    carry_next = Shift_Carry_Out;
        endcase
    end

    // State, remaining count and result registers.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state           <= IDLE;
            rem             <= '0;
            Shift_Out       <= '0;
            Shift_Carry_Out <= 1'b0;
        end else begin
            state           <= state_next;
            rem             <= rem_next;
            Shift_Out       <= out_next;
            Shift_Carry_Out <= carry_next;
        end
    end

`ifdef LSL_SHIFT_ZERO_FLAG_EN
    // Zero flag captured only when a result enters DONE (DONE->DONE only happens via a new Start).
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            Shift_Zero <= 1'b0;
        end else if (state_next == DONE) begin
            Shift_Zero <= (out_next == '0);
        end
    end
`endif

    assign Busy      = (state == SHIFT);
    assign Done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: doc/lsl_shift_seq.md
Name: lsl_shift_seq

Overview:
Multi-cycle ARM logical-shift-left (LSL) unit for the barrel-shifter datapath; the left-shift counterpart of the existing right-shift block.
- Shifts a 32-bit operand left by an 8-bit amount with ARMv7 carry-out semantics.
- Processes up to STEP bits per clock, trading latency for area.
- Start/Busy/Done handshake toward the execute-stage controller.

Parameters:
STEP, 4, max bits shifted per SHIFT cycle (legal 1..32)

Ports:
CLK  input  1  clock, rising edge
RST_n  input  1  reset, asynchronous, active-low
Start  input  1  request; sampled only in IDLE or DONE
Shift_Data  input  [32:1]  operand
Shift_Num  input  [8:1]  shift amount 0..255
Carry_In  input  1  current CPSR C flag
Shift_Out  output  [32:1]  registered result
Shift_Carry_Out  output  1  registered carry-out
Busy  output  1  high while in SHIFT
Done  output  1  one-cycle pulse, result valid

Behaviour:
- Reset (async, RST_n=0): state=IDLE; Shift_Out=0, Shift_Carry_Out=0, Busy=0, Done=0; internal remaining count=0. Reset mid-operation aborts; no Done is produced.
- States: IDLE, SHIFT, DONE. Busy = (state==SHIFT); Done = (state==DONE).
- IDLE/DONE with Start=1 at edge:
  - load Shift_Out<=Shift_Data, Shift_Carry_Out<=Carry_In, rem<=min(Shift_Num,33).
  - Go to DONE if Shift_Num==0, else to SHIFT.
- IDLE/DONE with Start=0: DONE->IDLE; IDLE stays IDLE.
- Start while in SHIFT is ignored and does not restart.
- SHIFT, each edge:
  - k=min(rem,STEP).
  - Shift_Out<=Shift_Out<<k; Shift_Carry_Out<=the last bit shifted out, i.e. Shift_Out[33-k].
  - rem<=rem-k.
  - Go to DONE when rem-k==0.
- Semantics:
  - n=0: out=data, carry=Carry_In.
  - 1<=n<=32: out=data<<n, carry=data[33-n].
  - n>32: saturated to 33, giving out=0, carry=0.
- Latency from the Start edge: ceil(min(n,33)/STEP) SHIFT cycles, then Done high for exactly 1 cycle. n=0 gives Done on the cycle after Start.
- Shift_Out and Shift_Carry_Out hold their values after Done until the next accepted Start.
- Start during DONE is accepted: back-to-back operation with no IDLE bubble.

Optional Feature:
- Macro LSL_SHIFT_ZERO_FLAG_EN.
- Defined: extra output Shift_Zero (1 bit), registered.
  - Updated only on the transition into DONE: equals (final Shift_Out==0).
  - Reset value 0; holds its value otherwise.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package shift_pkg:
  - state enum (IDLE, SHIFT, DONE).
  - DATA_W=32, AMT_W=8, SAT_AMT=33.
  - Carry-select encoding shared with the right-shift block.
- Sub-module lsl_step: combinational one-step shifter. Inputs: value, k (0..STEP), carry. Outputs: shifted value and new carry; k=0 passes both through. Instantiated once inside the SHIFT datapath.

Test Plan:
- Shift_Data=0x8000_0001, Shift_Num=1, Carry_In=0, STEP=4 -> after 1 SHIFT cycle Done pulses; Shift_Out=0x0000_0002, Shift_Carry_Out=1.
- Shift_Data=0x1234_5678, Shift_Num=0, Carry_In=1 -> Busy never rises; Done the next cycle; Shift_Out=0x1234_5678, Shift_Carry_Out=1.
- Shift_Data=0x0000_0001, Shift_Num=32 -> Busy for 8 cycles; Shift_Out=0, Shift_Carry_Out=1. Repeat with Shift_Num=200 on 0xFFFF_FFFF -> 9 cycles; Shift_Out=0, Shift_Carry_Out=0.
- Shift_Num=7 on 0x0F00_0000 -> Shift_Out=0x8000_0000, Shift_Carry_Out=1 after 2 cycles. Pulse Start with different data on the 2nd SHIFT cycle -> the pulse is ignored and the result is unchanged. Start asserted in the DONE cycle -> new operation accepted immediately.
- RST_n low on the 3rd SHIFT cycle of a Shift_Num=20 operation -> all outputs 0 asynchronously; no Done; IDLE after release.
- With LSL_SHIFT_ZERO_FLAG_EN defined: Shift_Num=40 -> Shift_Zero=1. Shift_Num=4 on 0x1 -> Shift_Zero=0.
